// File: rtl/led_bar_hold_decay.sv
// LED bar display stage with instantaneous attack and tick-clocked hold-then-fall decay.
// Accepts an MSB-first thermometer bar and drives registered LED and level outputs.
// Optional feature: define PEAK_DOT_EN to keep a peak dot lit above the falling bar.
module led_bar_hold_decay #(
  parameter int unsigned HOLD_TICKS  = 250,
  parameter int unsigned DECAY_TICKS = 25,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bar_in,
  input  logic       bar_valid,
  input  logic       tick,
  output logic [7:0] led_out,
  output logic [3:0] level_out
);

  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] DecayLast = CNT_W'(DECAY_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StHold, StDecay} state_e;

  state_e           state;
  logic [3:0]       disp;
  logic [3:0]       target;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] dec_cnt;
  logic [3:0]       level_in;
  logic [3:0]       tgt_eff;
  logic             attack;
`ifdef PEAK_DOT_EN
  logic [3:0]       peak;
`endif

  // MSB-first thermometer bar for a level 0..8
  function automatic logic [7:0] bar_of(input logic [3:0] lvl);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = (i < int'(lvl));
    end
    return b;
  endfunction

  // Leading-ones count from bit7; bits below the first zero are ignored
  always_comb begin
    logic run;
    level_in = '0;
    run      = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (run && bar_in[i]) level_in = level_in + 4'd1;
      else                  run      = 1'b0;
    end
  end

  // Attack decode; a tick in the same cycle as a non-attack strobe sees the new target
  always_comb begin
    tgt_eff = bar_valid ? level_in : target;
    if (state == StIdle) attack = bar_valid && (level_in != 4'd0);
    else                 attack = bar_valid && (level_in >= disp);
  end

  // Ballistic FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      disp      <= '0;
      target    <= '0;
      hold_cnt  <= '0;
      dec_cnt   <= '0;
      led_out   <= '0;
      level_out <= '0;
`ifdef PEAK_DOT_EN
      peak      <= '0;
`endif
    end else begin
`ifdef PEAK_DOT_EN
      led_out <= bar_of(disp) | ((peak > disp) ? (8'd1 << (4'd8 - peak)) : 8'd0);
`else
      led_out <= bar_of(disp);
`endif
      level_out <= disp;
      if (bar_valid) target <= level_in;

      if (attack) begin
        // Attack wins over a simultaneous tick
        disp     <= level_in;
        hold_cnt <= '0;
        dec_cnt  <= '0;
        state    <= StHold;
`ifdef PEAK_DOT_EN
        peak     <= level_in;
`endif
      end else if (tick) begin
        unique case (state)
          StIdle: ;
          StHold: begin
            if (hold_cnt == HoldLast) begin
              hold_cnt <= '0;
              if (tgt_eff != disp) begin
                state   <= StDecay;
                dec_cnt <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          StDecay: begin
            if (dec_cnt == DecayLast) begin
              dec_cnt <= '0;
              // disp >= 1 here, so compare disp <= target+1 to avoid underflow
              if (disp <= tgt_eff + 4'd1) begin
                disp     <= tgt_eff;
                hold_cnt <= '0;
                if (tgt_eff != 4'd0) begin
                  state <= StHold;
                end else begin
                  state <= StIdle;
`ifdef PEAK_DOT_EN
                  peak  <= '0;
`endif
                end
              end else begin
                disp <= disp - 4'd1;
              end
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_bar_hold_decay.sv
// Self-checking bench for led_bar_hold_decay with HOLD_TICKS=4, DECAY_TICKS=2.
// Directed scenarios followed by randomized traffic against a countdown-style reference model.
module tb_led_bar_hold_decay;

  localparam int H = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bar_in;
  logic       bar_valid;
  logic       tick;
  logic [7:0] led_out;
  logic [3:0] level_out;

  led_bar_hold_decay #(
    .HOLD_TICKS (H),
    .DECAY_TICKS(D),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bar_in   (bar_in),
    .bar_valid(bar_valid),
    .tick     (tick),
    .led_out  (led_out),
    .level_out(level_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = dark, 1 = holding, 2 = falling; hold/fall tracked as ticks left
  int m_mode, m_disp, m_tgt, m_hleft, m_dleft, m_peak;
  int exp_led, exp_lvl;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int therm(input int n);
    return (n == 0) ? 0 : (((1 << n) - 1) << (8 - n));
  endfunction

  function automatic int lead_ones(input logic [7:0] b);
    int n = 0;
    while (n < 8 && b[7-n]) n++;
    return n;
  endfunction

  task automatic model_step(input bit r, input bit bv, input logic [7:0] b, input bit t);
    int lvl;
    if (r) begin
      exp_led = 0; exp_lvl = 0;
      m_mode = 0; m_disp = 0; m_tgt = 0; m_hleft = H; m_dleft = D; m_peak = 0;
      return;
    end
    exp_led = therm(m_disp);
`ifdef PEAK_DOT_EN
    if (m_peak > m_disp) exp_led = exp_led | (1 << (8 - m_peak));
`endif
    exp_lvl = m_disp;
    lvl = lead_ones(b);
    if (bv) m_tgt = lvl;
    if (bv && ((m_mode == 0 && lvl > 0) || (m_mode != 0 && lvl >= m_disp))) begin
      m_disp = lvl; m_mode = 1; m_hleft = H; m_peak = lvl;
    end else if (t && m_mode == 1) begin
      m_hleft--;
      if (m_hleft == 0) begin
        m_hleft = H;
        if (m_tgt != m_disp) begin m_mode = 2; m_dleft = D; end
      end
    end else if (t && m_mode == 2) begin
      m_dleft--;
      if (m_dleft == 0) begin
        m_dleft = D;
        if (m_disp - 1 <= m_tgt) begin
          m_disp = m_tgt; m_hleft = H;
          if (m_tgt > 0) m_mode = 1;
          else begin m_mode = 0; m_peak = 0; end
        end else begin
          m_disp = m_disp - 1;
        end
      end
    end
  endtask

  // One clock: drive, let the DUT sample, advance the model, check outputs
  task automatic cyc(input bit r, input bit bv, input logic [7:0] b, input bit t);
    reset = r; bar_valid = bv; bar_in = b; tick = t;
    @(posedge clk);
    model_step(r, bv, b, t);
    #1;
    chk("led_out", int'(led_out), exp_led);
    chk("level_out", int'(level_out), exp_lvl);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, i[0]);
  endtask

  initial begin
    bit found;
    reset = 1'b1; bar_valid = 1'b0; bar_in = 8'h00; tick = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Attack and full decay
    cyc(1'b0, 1'b1, 8'hF8, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("attack_f8", int'(led_out), 8'hF8);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    ticks(40);
    chk("decay_to_zero", int'(led_out), 8'h00);

    // Re-attack during decay at E0
    cyc(1'b0, 1'b1, 8'hF8, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      found = (m_disp == 3 && m_mode == 2);
    end
    chk("reach_e0_bound", int'(found), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hFC, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("reattack_fc", int'(led_out), 8'hFC);
    ticks(6);
    chk("hold_restarted", int'(led_out), 8'hFC);

    // Lower target: falls from FC and settles at C0
    cyc(1'b0, 1'b1, 8'hC0, 1'b0);
    ticks(60);
    chk("settle_c0", int'(led_out), 8'hC0);

    // Reset mid-stream for 3 cycles, then ticks change nothing
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1);
    ticks(12);
    chk("post_reset_dark", int'(led_out), 8'h00);

    // Malformed bar
    cyc(1'b0, 1'b1, 8'hDF, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("malformed_lvl", int'(level_out), 2);

    // Simultaneous strobe and tick with attack
    ticks(3);
    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    ticks(5);
    chk("sim_attack", int'(led_out), 8'hF0);

`ifdef PEAK_DOT_EN
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    ticks(10);
    chk("peak_dot", int'(led_out), 8'hFF);
    ticks(40);
    chk("peak_cleared", int'(led_out), 8'h00);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      bit r, bv, t;
      b  = ($urandom_range(0, 1) == 0) ? 8'(therm($urandom_range(0, 8))) : 8'($urandom);
      bv = ($urandom_range(0, 11) == 0);
      t  = ($urandom_range(0, 1) == 0);
      r  = ($urandom_range(0, 399) == 0);
      cyc(r, bv, b, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_bar_hold_decay.md
Name: led_bar_hold_decay

Overview:
Downstream display stage for the audio intensity meter. Consumes the 8-bit MSB-first thermometer bar (8'hFF<<n encoding) and drives the board LEDs. Attack is instantaneous. Decay is a hold-then-fall ballistic clocked by an external tick, so the bar does not flicker at meter update rate.

Parameters:
HOLD_TICKS, 250, ticks a displayed level is held before decay starts; must be >=1
DECAY_TICKS, 25, ticks per one-LED step during decay; must be >=1
CNT_W, 16, width of the hold/decay tick counters; must hold HOLD_TICKS-1 and DECAY_TICKS-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bar_in  input  8  thermometer bar from intensity meter, MSB-first
bar_valid  input  1  one-cycle strobe, bar_in is sampled when high
tick  input  1  one-cycle timing enable (e.g. 1 kHz); ignored when low
led_out  output  8  registered displayed bar, same MSB-first encoding
level_out  output  4  displayed level 0..8 (registered, equals disp)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: led_out=0, level_out=0, disp=0, target=0, counters=0, state=S_IDLE. Reset mid-operation aborts immediately; no residual hold.
- level_in = count of consecutive 1s from bit7 downward (0..8). Bits below the first 0 are ignored (8'b1101_1111 -> 2).
- target register: set to level_in on every bar_valid.
- FSM:
  S_IDLE: disp=0. bar_valid with level_in>0 -> disp=level_in, hold_cnt=0, go to S_HOLD.
  S_HOLD: tick -> hold_cnt++. On tick with hold_cnt==HOLD_TICKS-1: if target==disp, stay in S_HOLD with hold_cnt=0. Otherwise go to S_DECAY with dec_cnt=0.
  S_DECAY: tick -> dec_cnt++. On tick with dec_cnt==DECAY_TICKS-1: disp=disp-1, dec_cnt=0. If disp-1<=target: disp=target, then go to S_HOLD (hold_cnt=0) if target>0, else S_IDLE.
- Attack (S_HOLD/S_DECAY): bar_valid with level_in>=disp -> disp=level_in, hold_cnt=0, dec_cnt=0, go to S_HOLD. Attack with level_in==disp restarts the hold.
- bar_valid with level_in<disp updates target only; displayed bar is unchanged.
- Simultaneous bar_valid and tick in the same cycle: bar_valid processing wins; that tick is discarded when an attack occurs. On a non-attack bar_valid, the tick is counted using the new target.
- disp never underflows below 0 and never exceeds 8.
- Output: led_out <= 8'hFF << (8-disp) (disp=0 -> 8'h00); level_out <= disp.
- Latency: bar_valid sampled at edge k -> disp updated at edge k; led_out/level_out valid after edge k+1.

Optional Feature:
PEAK_DOT_EN: when defined, adds a peak register peak (0..8).
- peak is set to disp on each attack.
- peak is held while the FSM is in S_DECAY.
- peak is cleared on entry to S_IDLE and on reset.
- led_out = bar OR (peak>disp ? 1<<(8-peak) : 0), so the peak LED stays lit above the falling bar.
- When not defined: no peak register; led_out is the plain bar.

Test Plan:
All tests use HOLD_TICKS=4, DECAY_TICKS=2.
- Reset: assert reset 3 cycles mid-stream -> led_out=8'h00, level_out=0, subsequent ticks produce no change.
- Attack and full decay: bar_in=8'hF8 with bar_valid, then bar_in=8'h00 strobe.
  - led_out=8'hF8 after edge k+1.
  - Stays there 4 ticks.
  - Then steps F0,E0,C0,80,00 every 2 ticks; FSM ends in S_IDLE.
- Re-attack during decay: at led_out=8'hE0 in S_DECAY, bar_in=8'hFC -> led_out=8'hFC next cycle; hold restarts for a full 4 ticks.
- Lower target: disp=6 (8'hFC), then bar_in=8'hC0.
  - led_out stays 8'hFC through hold.
  - Decays FC,F8,F0,E0,C0 and stops at 8'hC0 in S_HOLD.
  - Remains C0 indefinitely while ticks continue.
- Malformed input plus simultaneous events:
  - bar_in=8'b1101_1111 -> level_out=2.
  - bar_valid and tick together with level_in>disp -> attack taken, counters zeroed.
- PEAK_DOT_EN: attack 8'hFF, then input 8'h00 -> after the first decay step led_out=8'hFF (bar 8'hFE | dot 8'h01). The dot stays at bit0 while the bar falls, and clears when level reaches 0.
